// File: rtl/arc4_pkg.sv
// Shared ARC4 definitions: FSM states, S-box size and key byte extraction.
package arc4_pkg;

    localparam int S_SIZE  = 256;
    localparam int KEY_MAX = 256;

    typedef enum logic [3:0] {
        IDLE, INIT,
        KSA_RD_I, KSA_RD_J, KSA_WR_I, KSA_WR_J,
        LEN_RD, LEN_WR,
        PRGA_RD_I, PRGA_RD_J, PRGA_WR_I, PRGA_WR_J,
        PRGA_RD_PAD, PRGA_RD_PT, PRGA_WR_CT,
        DONE
    } state_t;

    // Key is big-endian: byte 0 is the most significant of the kl valid bytes.
    function automatic logic [7:0] key_byte(input logic [KEY_MAX-1:0] key, input int kl, input int idx);
        return key[(kl - 1 - idx) * 8 +: 8];
    endfunction

endpackage

// File: rtl/arc4_sbox_init.sv
// Fills the S-box RAM with S[i]=i, one write per cycle, using an en/rdy start.
module arc4_sbox_init import arc4_pkg::*; (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic       rdy,
    output logic [7:0] addr,
    output logic [7:0] wrdata,
    output logic       wren
);

    assign wrdata = addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdy  <= 1'b1;
            addr <= '0;
            wren <= 1'b0;
        end else if (rdy) begin
            if (en) begin
                rdy  <= 1'b0;
                wren <= 1'b1;
                addr <= '0;
            end
        end else if (addr == 8'(S_SIZE - 1)) begin
            rdy  <= 1'b1;
            wren <= 1'b0;
            addr <= '0;
        end else begin
            addr <= addr + 1'b1;
        end
    end

endmodule

// File: rtl/arc4_encrypt.sv
// ARC4 encryptor: S-box init, key schedule, then keystream XOR of a
// length-prefixed plaintext buffer into a length-prefixed ciphertext buffer.
module arc4_encrypt import arc4_pkg::*; #(
    parameter int KEY_W  = 24,
    parameter int MEM_AW = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic              rdy,
    input  logic [KEY_W-1:0]  key,
    output logic [7:0]        s_addr,
    output logic [7:0]        s_wrdata,
    output logic              s_wren,
    input  logic [7:0]        s_rddata,
    output logic [MEM_AW-1:0] pt_addr,
    input  logic [7:0]        pt_rddata,
    output logic [MEM_AW-1:0] ct_addr,
    output logic [7:0]        ct_wrdata,
    output logic              ct_wren
);

    localparam int KL  = KEY_W / 8;
    localparam int KIW = (KL > 1) ? $clog2(KL) : 1;

    state_t            state;
    logic              ph;
    logic [7:0]        i, j, si, sj, ptb;
    logic [MEM_AW-1:0] k, len;
    logic [KIW-1:0]    kidx;
    logic [KEY_W-1:0]  key_q;
    logic [7:0]        s_addr_q, s_wrdata_q;
    logic              s_wren_q;
    logic              init_rdy, init_wren, start;
    logic [7:0]        init_addr, init_wrdata;
    logic [7:0]        kb, j_ksa, j_prga;

    assign start  = rdy & en & init_rdy;
    assign kb     = key_byte(KEY_MAX'(key_q), KL, int'(kidx));
    assign j_ksa  = j + s_rddata + kb;
    assign j_prga = j + s_rddata;

    arc4_sbox_init u_init (
        .clk    (clk),
        .rst    (rst),
        .en     (start),
        .rdy    (init_rdy),
        .addr   (init_addr),
        .wrdata (init_wrdata),
        .wren   (init_wren)
    );

    // The init engine owns the S port only while the FSM sits in INIT.
    assign s_addr   = (state == INIT) ? init_addr   : s_addr_q;
    assign s_wrdata = (state == INIT) ? init_wrdata : s_wrdata_q;
    assign s_wren   = (state == INIT) ? init_wren   : s_wren_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            rdy        <= 1'b1;
            ph         <= 1'b0;
            i          <= '0;
            j          <= '0;
            si         <= '0;
            sj         <= '0;
            ptb        <= '0;
            k          <= '0;
            len        <= '0;
            kidx       <= '0;
            key_q      <= '0;
            s_addr_q   <= '0;
            s_wrdata_q <= '0;
            s_wren_q   <= 1'b0;
            pt_addr    <= '0;
            ct_addr    <= '0;
            ct_wrdata  <= '0;
            ct_wren    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    key_q <= key;
                    rdy   <= 1'b0;
                    i     <= '0;
                    j     <= '0;
                    kidx  <= '0;
                    ph    <= 1'b0;
                    state <= INIT;
                end
                INIT: if (init_wren && init_addr == 8'(S_SIZE - 1)) state <= KSA_RD_I;
                KSA_RD_I: begin
                    s_addr_q <= i;
                    s_wren_q <= 1'b0;
                    ph       <= 1'b0;
                    state    <= KSA_RD_J;
                end
                // ph=0 is the RAM latency cycle; ph=1 consumes the read data.
                KSA_RD_J: if (!ph) ph <= 1'b1;
                else begin
                    ph       <= 1'b0;
                    si       <= s_rddata;
                    j        <= j_ksa;
                    s_addr_q <= j_ksa;
                    kidx     <= (kidx == KIW'(KL - 1)) ? '0 : kidx + 1'b1;
                    state    <= KSA_WR_I;
                end
                KSA_WR_I: if (!ph) ph <= 1'b1;
                else begin
                    ph         <= 1'b0;
                    sj         <= s_rddata;
                    s_addr_q   <= i;
                    s_wrdata_q <= s_rddata;
                    s_wren_q   <= 1'b1;
                    state      <= KSA_WR_J;
                end
                KSA_WR_J: begin
                    s_addr_q   <= j;
                    s_wrdata_q <= si;
                    s_wren_q   <= 1'b1;
                    i          <= i + 1'b1;
                    if (i == 8'hFF) begin
                        j       <= '0;
                        pt_addr <= '0;
                        ph      <= 1'b0;
                        state   <= LEN_RD;
                    end else begin
                        state <= KSA_RD_I;
                    end
                end
                LEN_RD: begin
                    s_wren_q <= 1'b0;
                    if (!ph) ph <= 1'b1;
                    else begin
                        ph    <= 1'b0;
                        len   <= MEM_AW'(pt_rddata);
                        state <= LEN_WR;
                    end
                end
                LEN_WR: begin
                    ct_addr   <= '0;
                    ct_wrdata <= 8'(len);
                    ct_wren   <= 1'b1;
                    k         <= MEM_AW'(1);
                    i         <= '0;
                    j         <= '0;
                    state     <= (len == '0) ? DONE : PRGA_RD_I;
                end
                PRGA_RD_I: begin
                    ct_wren  <= 1'b0;
                    i        <= i + 1'b1;
                    s_addr_q <= i + 1'b1;
                    ph       <= 1'b0;
                    state    <= PRGA_RD_J;
                end
                PRGA_RD_J: if (!ph) ph <= 1'b1;
                else begin
                    ph       <= 1'b0;
                    si       <= s_rddata;
                    j        <= j_prga;
                    s_addr_q <= j_prga;
                    state    <= PRGA_WR_I;
                end
                PRGA_WR_I: if (!ph) ph <= 1'b1;
                else begin
                    ph         <= 1'b0;
                    sj         <= s_rddata;
                    s_addr_q   <= i;
                    s_wrdata_q <= s_rddata;
                    s_wren_q   <= 1'b1;
                    pt_addr    <= k;
                    state      <= PRGA_WR_J;
                end
                PRGA_WR_J: begin
                    s_addr_q   <= j;
                    s_wrdata_q <= si;
                    state      <= PRGA_RD_PAD;
                end
                // Post-swap S[i]=sj, S[j]=si, so the pad index is si+sj either way.
                PRGA_RD_PAD: begin
                    s_wren_q <= 1'b0;
                    s_addr_q <= si + sj;
                    ptb      <= pt_rddata;
                    state    <= PRGA_RD_PT;
                end
                PRGA_RD_PT: state <= PRGA_WR_CT;
                PRGA_WR_CT: begin
                    ct_addr   <= k;
                    ct_wrdata <= s_rddata ^ ptb;
                    ct_wren   <= 1'b1;
                    k         <= k + 1'b1;
                    state     <= (k == len) ? DONE : PRGA_RD_I;
                end
                DONE: begin
                    ct_wren <= 1'b0;
                    rdy     <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_arc4_encrypt.sv
// Directed + randomized bench for arc4_encrypt against an array-based ARC4 model.
module tb_arc4_encrypt;

    logic        clk, rst, en, rdy;
    logic [23:0] key;
    logic [7:0]  s_addr, s_wrdata, s_rddata, pt_rddata, ct_wrdata;
    logic        s_wren, ct_wren;
    logic [7:0]  pt_addr, ct_addr;

    logic [7:0] s_mem  [256];
    logic [7:0] pt_mem [256];
    logic [7:0] ct_mem [256];
    logic [7:0] exp_ct [256];
    logic [7:0] exp_s  [256];
    logic [7:0] tmp    [256];
    logic [7:0] ct1    [10];
    logic [7:0] pt1    [10];
    int ct_total = 0;
    int errors = 0;
    int checks = 0;

    arc4_encrypt #(.KEY_W(24), .MEM_AW(8)) dut (
        .clk(clk), .rst(rst), .en(en), .rdy(rdy), .key(key),
        .s_addr(s_addr), .s_wrdata(s_wrdata), .s_wren(s_wren), .s_rddata(s_rddata),
        .pt_addr(pt_addr), .pt_rddata(pt_rddata),
        .ct_addr(ct_addr), .ct_wrdata(ct_wrdata), .ct_wren(ct_wren)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (s_wren) s_mem[s_addr] <= s_wrdata;
        s_rddata  <= s_mem[s_addr];
        pt_rddata <= pt_mem[pt_addr];
        if (ct_wren) begin
            ct_mem[ct_addr] <= ct_wrdata;
            ct_total++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Straight ARC4 from its definition: KSA over a 256-entry array, then PRGA.
    task automatic model(input logic [23:0] k, input int L, input logic [7:0] src [256]);
        int s [256];
        int a, b, t;
        for (int n = 0; n < 256; n++) s[n] = n;
        b = 0;
        for (int n = 0; n < 256; n++) begin
            b = (b + s[n] + int'((k >> (8 * (2 - (n % 3)))) & 24'hFF)) % 256;
            t = s[n]; s[n] = s[b]; s[b] = t;
        end
        exp_ct[0] = 8'(L);
        a = 0; b = 0;
        for (int m = 1; m <= L; m++) begin
            a = (a + 1) % 256;
            b = (b + s[a]) % 256;
            t = s[a]; s[a] = s[b]; s[b] = t;
            exp_ct[m] = 8'(s[(s[a] + s[b]) % 256]) ^ src[m];
        end
        for (int n = 0; n < 256; n++) exp_s[n] = 8'(s[n]);
    endtask

    task automatic load_plain();
        for (int n = 0; n < 10; n++) pt_mem[n] = pt1[n];
    endtask

    task automatic load_rand(input int L);
        pt_mem[0] = 8'(L);
        for (int n = 1; n <= L; n++) pt_mem[n] = 8'($urandom);
    endtask

    task automatic run_and_check(input string tag, input logic [23:0] k, input int L, input bit hammer);
        int cyc, n0, bad;
        model(k, L, pt_mem);
        n0 = ct_total;
        @(negedge clk);
        key = k;
        en  = 1'b1;
        @(posedge clk);
        #1 en = 1'b0;
        chk({tag, "_rdy_fall"}, rdy, 0);
        cyc = 0;
        while (!rdy && cyc < 5000) begin
            @(posedge clk);
            #1 cyc++;
            if (hammer) begin
                en  = 1'($urandom_range(0, 1));
                key = 24'($urandom);
            end
        end
        en  = 1'b0;
        key = k;
        chk({tag, "_latency_ok"}, (cyc <= 256 + 6 * 256 + 4 + 9 * L + 2) ? 1 : 0, 1);
        @(negedge clk);
        chk({tag, "_ct_writes"}, ct_total - n0, L + 1);
        for (int b = 0; b <= L; b++) chk($sformatf("%s_ct[%0d]", tag, b), ct_mem[b], exp_ct[b]);
        bad = 0;
        for (int n = 0; n < 256; n++) if (s_mem[n] !== exp_s[n]) bad++;
        chk({tag, "_sbox_final_mismatches"}, bad, 0);
    endtask

    initial begin
        ct1 = '{8'h09, 8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
        pt1 = '{8'h09, 8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
        rst = 1'b1;
        en  = 1'b0;
        key = '0;
        repeat (3) @(negedge clk);
        chk("rst_rdy", rdy, 1);
        chk("rst_s_wren", s_wren, 0);
        chk("rst_ct_wren", ct_wren, 0);
        chk("rst_s_addr", s_addr, 0);
        chk("rst_pt_addr", pt_addr, 0);
        chk("rst_ct_addr", ct_addr, 0);
        chk("rst_wrdata", {s_wrdata, ct_wrdata}, 0);
        rst = 1'b0;

        // Known-answer vector "Key"/"Plaintext"
        load_plain();
        run_and_check("t1", 24'h4B6579, 9, 1'b0);
        for (int n = 0; n < 10; n++) chk($sformatf("t1_kat[%0d]", n), ct_mem[n], ct1[n]);

        // Empty message
        pt_mem[0] = 8'h00;
        run_and_check("t2", 24'h000000, 0, 1'b0);

        // Round trip: decrypting the DUT ciphertext must give back the plaintext
        load_rand(46);
        run_and_check("t3", 24'h00001A, 46, 1'b0);
        for (int n = 0; n < 256; n++) tmp[n] = ct_mem[n];
        model(24'h00001A, 46, tmp);
        for (int n = 1; n <= 46; n++) chk($sformatf("t3_rt[%0d]", n), exp_ct[n], pt_mem[n]);

        // Maximum length
        load_rand(255);
        run_and_check("t4", 24'hFFFFFF, 255, 1'b0);

        // Reset in the middle of the key schedule, then a clean rerun
        load_plain();
        @(negedge clk);
        key = 24'h4B6579;
        en  = 1'b1;
        @(negedge clk);
        en = 1'b0;
        repeat (600) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t5_rst_rdy", rdy, 1);
        chk("t5_rst_s_wren", s_wren, 0);
        chk("t5_rst_s_addr", s_addr, 0);
        chk("t5_rst_ct_wren", ct_wren, 0);
        @(negedge clk);
        rst = 1'b0;
        run_and_check("t5", 24'h4B6579, 9, 1'b0);
        for (int n = 0; n < 10; n++) chk($sformatf("t5_kat[%0d]", n), ct_mem[n], ct1[n]);

        // en and key toggled throughout a busy run
        load_rand(20);
        run_and_check("t6", 24'($urandom), 20, 1'b1);
        repeat (5) @(negedge clk);
        chk("t6_idle_after", rdy, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
